// File: rtl/hpi_bus_sequencer_pkg.sv
// Shared types and constants for the HPI bus sequencer.
package hpi_pkg;

  localparam int unsigned HPI_CNT_W  = 4;
  localparam int unsigned HPI_ADDR_W = 2;
  localparam int unsigned HPI_DATA_W = 16;

  localparam logic [HPI_ADDR_W-1:0] HPI_DATA    = 2'd0;
  localparam logic [HPI_ADDR_W-1:0] HPI_MAILBOX = 2'd1;
  localparam logic [HPI_ADDR_W-1:0] HPI_ADDRESS = 2'd2;
  localparam logic [HPI_ADDR_W-1:0] HPI_STATUS  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } hpi_state_e;

endpackage

// File: rtl/hpi_bus_sequencer_if.sv
// Avalon-MM slave side of the HPI bus sequencer.
interface hpi_bus_sequencer_if;
  import hpi_pkg::*;

  logic [HPI_ADDR_W-1:0] address;
  logic                  chipselect;
  logic                  read;
  logic                  write;
  logic [31:0]           writedata;
  logic [31:0]           readdata;
  logic                  waitrequest;

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata, waitrequest
  );

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata, waitrequest
  );

endinterface

// File: rtl/hpi_bus_sequencer_sync2.sv
// Two-flop synchronizer for the asynchronous HPI interrupt.
// Only present when HPI_IRQ_SYNC_EN is defined, matching its sole use.
`ifdef HPI_IRQ_SYNC_EN
module hpi_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;

  // Two-stage shift into the clk domain; q is the second stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule
`endif

// File: rtl/hpi_bus_sequencer.sv
// Avalon-MM to Cypress-style HPI bus sequencer.
// Each Avalon access becomes SETUP / STROBE / HOLD phases on the HPI pins,
// followed by a single DONE cycle that releases waitrequest.
// Optional: HPI_IRQ_SYNC_EN adds a 2-flop synchronizer for otg_int -> irq.
module hpi_bus_sequencer
  import hpi_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  hpi_bus_sequencer_if.slave    avs,
  output logic [HPI_ADDR_W-1:0] otg_addr,
  output logic                  otg_cs_n,
  output logic                  otg_rd_n,
  output logic                  otg_wr_n,
  output logic [HPI_DATA_W-1:0] otg_data_out,
  output logic                  otg_data_oe,
  input  logic [HPI_DATA_W-1:0] otg_data_in,
  input  logic                  otg_int,
  output logic                  irq
);

  if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup
    $error("SETUP_CYC out of range 1..15");
  end
  if (STROBE_CYC < 1 || STROBE_CYC > 15) begin : g_bad_strobe
    $error("STROBE_CYC out of range 1..15");
  end
  if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
    $error("HOLD_CYC out of range 1..15");
  end

  localparam logic [HPI_CNT_W-1:0] SETUP_LD  = HPI_CNT_W'(SETUP_CYC - 1);
  localparam logic [HPI_CNT_W-1:0] STROBE_LD = HPI_CNT_W'(STROBE_CYC - 1);
  localparam logic [HPI_CNT_W-1:0] HOLD_LD   = HPI_CNT_W'(HOLD_CYC - 1);

  hpi_state_e            state_q, state_d;
  logic [HPI_CNT_W-1:0]  cnt_q, cnt_d;
  logic [HPI_ADDR_W-1:0] addr_q;
  logic [HPI_DATA_W-1:0] wdata_q;
  logic                  is_wr_q;
  logic [HPI_DATA_W-1:0] rdata_q;
  logic                  accept;
  logic                  capture;

  logic unused_wd_hi;
  assign unused_wd_hi = ^avs.writedata[31:16];

  // State, phase counter and request latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= avs.address;
        wdata_q <= avs.writedata[HPI_DATA_W-1:0];
        is_wr_q <= avs.write;
      end
      if (capture) begin
        rdata_q <= otg_data_in;
      end
    end
  end

  // Next-state, counter reload and pin decode.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    accept          = 1'b0;
    capture         = 1'b0;
    otg_addr        = '0;
    otg_cs_n        = 1'b1;
    otg_rd_n        = 1'b1;
    otg_wr_n        = 1'b1;
    otg_data_out    = '0;
    otg_data_oe     = 1'b0;
    avs.waitrequest = 1'b1;

    case (state_q)
      IDLE: begin
        if (avs.chipselect && (avs.read || avs.write)) begin
          accept  = 1'b1;
          state_d = SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      SETUP: begin
        otg_cs_n     = 1'b0;
        otg_addr     = addr_q;
        otg_data_out = wdata_q;
        otg_data_oe  = is_wr_q;
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STROBE: begin
        otg_cs_n     = 1'b0;
        otg_addr     = addr_q;
        otg_data_out = wdata_q;
        otg_data_oe  = is_wr_q;
        otg_rd_n     = is_wr_q;
        otg_wr_n     = ~is_wr_q;
        if (cnt_q == '0) begin
          capture = ~is_wr_q;
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        otg_cs_n     = 1'b0;
        otg_addr     = addr_q;
        otg_data_out = wdata_q;
        otg_data_oe  = is_wr_q;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        avs.waitrequest = 1'b0;
        state_d         = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign avs.readdata = {16'b0, rdata_q};

`ifdef HPI_IRQ_SYNC_EN
  hpi_sync2 u_irq_sync (
    .clk   (clk),
    .reset (reset),
    .d     (otg_int),
    .q     (irq)
  );
`else
  logic unused_otg_int;
  assign unused_otg_int = otg_int;
  assign irq = 1'b0;
`endif

endmodule
